// File: rtl/mem_access_ctrl.sv
// Load/store unit between a CPU port and a word-wide synchronous data memory.
// Sub-word stores use read-modify-write; byte lanes are big-endian.
module mem_access_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_we,
   output logic        mem_oe,
   input  logic [31:0] mem_dout,
   output logic [2:0]  dbg_state
);

   // Handshake: a request is accepted on a rising edge where ready=1 and req=1;
   // done pulses for one cycle when the access completes, err/rdata valid with it.

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_REQ   = 3'd1,
      RD_DATA  = 3'd2,
      RMW_REQ  = 3'd3,
      RMW_DATA = 3'd4,
      WR       = 3'd5,
      DONE     = 3'd6
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        acc_err;
   logic [1:0]  l_size;
   logic        l_sext;
   logic [1:0]  l_off;
   logic        l_err;
   logic [15:0] l_wdata;

   function automatic logic [31:0] extract_lane(input logic [31:0] w,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off,
                                                input logic        se);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      case (sz)
         SZ_BYTE: extract_lane = {{24{se & b[7]}}, b};
         SZ_HALF: extract_lane = {{16{se & h[15]}}, h};
         default: extract_lane = w;
      endcase
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] w,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off,
                                              input logic [15:0] d);
      logic [31:0] m;
      m = w;
      if (sz == SZ_HALF) begin
         if (off[1]) m[15:0]  = d;
         else        m[31:16] = d;
      end else begin
         case (off)
            2'd0:    m[31:24] = d[7:0];
            2'd1:    m[23:16] = d[7:0];
            2'd2:    m[15:8]  = d[7:0];
            default: m[7:0]   = d[7:0];
         endcase
      end
      merge_lane = m;
   endfunction

   assign acc_err = (size == 2'b11) ||
                    ((size == SZ_HALF) && addr[0]) ||
                    ((size == SZ_WORD) && (addr[1:0] != 2'b00));
   assign accept  = (state == IDLE) && req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (acc_err)              state_nxt = DONE;
               else if (!wr)             state_nxt = RD_REQ;
               else if (size == SZ_WORD) state_nxt = WR;
               else                      state_nxt = RMW_REQ;
            end
         end
         RD_REQ:   state_nxt = RD_DATA;
         RD_DATA:  state_nxt = DONE;
         RMW_REQ:  state_nxt = RMW_DATA;
         RMW_DATA: state_nxt = WR;
         WR:       state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready  = 1'b0;
      done   = 1'b0;
      err    = 1'b0;
      mem_oe = 1'b0;
      mem_we = 1'b0;
      case (state)
         IDLE:    ready  = 1'b1;
         RD_REQ, RD_DATA, RMW_REQ, RMW_DATA:
                  mem_oe = 1'b1;
         WR:      mem_we = 1'b1;
         DONE: begin
            done = 1'b1;
            err  = l_err;
         end
         default: ready  = 1'b0;
      endcase
   end

   assign dbg_state = state;

   // mem_din is loaded with wdata at accept for word stores, or with the merged
   // word at the end of RMW_DATA, so it is already stable throughout WR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l_size   <= 2'b00;
         l_sext   <= 1'b0;
         l_off    <= 2'b00;
         l_err    <= 1'b0;
         l_wdata  <= 16'h0;
         mem_addr <= 32'h0;
         mem_din  <= 32'h0;
         rdata    <= 32'h0;
      end else begin
         if (accept) begin
            l_size   <= size;
            l_sext   <= sign_ext;
            l_off    <= addr[1:0];
            l_err    <= acc_err;
            l_wdata  <= wdata[15:0];
            mem_addr <= {addr[31:2], 2'b00};
            if (wr && (size == SZ_WORD) && !acc_err)
               mem_din <= wdata;
         end
         if (state == RD_DATA)
            rdata <= extract_lane(mem_dout, l_size, l_off, l_sext);
         if (state == RMW_DATA)
            mem_din <= merge_lane(mem_dout, l_size, l_off, l_wdata);
      end
   end

endmodule
